instruction_decode: RTL and testbench

//   ID stage of the 5-stage RV32I pipeline. Consumes the IF/ID register

---
 rtl/instruction_decode.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_instruction_decode.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_decode.sv
// instruction_decode: RV32I ID stage. Decodes the IF/ID instruction, reads the
// 32x32 integer register file (write-first bypass from WB), detects load-use
// hazards and drives the ID/EX pipeline register feeding the execute stage.
module instruction_decode #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en_id_reg,
  input  logic                  i_flush,
  input  logic [31:0]           i_if_inst,
  input  logic [31:0]           i_if_pc,
  input  logic                  i_wb_we,
  input  logic [4:0]            i_wb_rd,
  input  logic [DATA_WIDTH-1:0] i_wb_data,
  input  logic                  i_ex_mem_rd,
  input  logic [4:0]            i_ex_rd,
  output logic                  o_load_use_stall,
  output logic [31:0]           o_id_pc,
  output logic [DATA_WIDTH-1:0] o_id_rs1_data,
  output logic [DATA_WIDTH-1:0] o_id_rs2_data,
  output logic [31:0]           o_id_imm,
  output logic [4:0]            o_id_rs1,
  output logic [4:0]            o_id_rs2,
  output logic [4:0]            o_id_rd,
  output logic [2:0]            o_id_funct3,
  output logic [3:0]            o_id_alu_op,
  output logic                  o_id_alu_src,
  output logic                  o_id_pc_src,
  output logic                  o_id_mem_rd,
  output logic                  o_id_mem_wr,
  output logic                  o_id_reg_we,
  output logic [1:0]            o_id_wb_sel,
  output logic                  o_id_branch,
  output logic                  o_id_jump,
  output logic                  o_id_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // Everything the decoder produces except the register operands.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        pc_src;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic        branch;
    logic        jump;
    logic        illegal;
  } ctrl_t;

  typedef struct packed {
    ctrl_t                 ctrl;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;
  } idex_t;

  // Instruction fields
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1_f;
  logic [4:0] rs2_f;
  logic [4:0] rd_f;

  assign opcode = i_if_inst[6:0];
  assign funct3 = i_if_inst[14:12];
  assign funct7 = i_if_inst[31:25];
  assign rs1_f  = i_if_inst[19:15];
  assign rs2_f  = i_if_inst[24:20];
  assign rd_f   = i_if_inst[11:7];

  // Immediate formats; B and J targets are always even
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign imm_i = {{20{i_if_inst[31]}}, i_if_inst[31:20]};
  assign imm_s = {{20{i_if_inst[31]}}, i_if_inst[31:25], i_if_inst[11:7]};
  assign imm_b = {{19{i_if_inst[31]}}, i_if_inst[31], i_if_inst[7],
                  i_if_inst[30:25], i_if_inst[11:8], 1'b0};
  assign imm_u = {i_if_inst[31:12], 12'h000};
  assign imm_j = {{11{i_if_inst[31]}}, i_if_inst[31], i_if_inst[19:12],
                  i_if_inst[20], i_if_inst[30:21], 1'b0};

  logic [DATA_WIDTH-1:0] rf_q [REG_NUM];
  ctrl_t                 dec_ctrl;
  logic                  rs1_used;
  logic                  rs2_used;
  logic                  writes_rd;
  logic                  has_funct3;
  logic                  illegal;
  logic [DATA_WIDTH-1:0] rs1_rdata;
  logic [DATA_WIDTH-1:0] rs2_rdata;
  idex_t                 idex_d;
  idex_t                 idex_q;

  // Decode opcode/funct into control bits, operand usage and immediate
  always_comb begin
    dec_ctrl   = '0;
    rs1_used   = 1'b0;
    rs2_used   = 1'b0;
    writes_rd  = 1'b0;
    has_funct3 = 1'b0;
    illegal    = 1'b0;
    case (opcode)
      OPC_LUI: begin
        writes_rd        = 1'b1;
        dec_ctrl.imm     = imm_u;
        dec_ctrl.alu_src = 1'b1;
      end
      OPC_AUIPC: begin
        writes_rd        = 1'b1;
        dec_ctrl.imm     = imm_u;
        dec_ctrl.alu_src = 1'b1;
        dec_ctrl.pc_src  = 1'b1;
      end
      OPC_JAL: begin
        writes_rd        = 1'b1;
        dec_ctrl.imm     = imm_j;
        dec_ctrl.alu_src = 1'b1;
        dec_ctrl.pc_src  = 1'b1;
        dec_ctrl.jump    = 1'b1;
        dec_ctrl.wb_sel  = WB_PC4;
      end
      OPC_JALR: begin
        illegal          = (funct3 != 3'b000);
        rs1_used         = 1'b1;
        writes_rd        = 1'b1;
        has_funct3       = 1'b1;
        dec_ctrl.imm     = imm_i;
        dec_ctrl.alu_src = 1'b1;
        dec_ctrl.jump    = 1'b1;
        dec_ctrl.wb_sel  = WB_PC4;
      end
      OPC_BRANCH: begin
        illegal         = (funct3 == 3'b010) || (funct3 == 3'b011);
        rs1_used        = 1'b1;
        rs2_used        = 1'b1;
        has_funct3      = 1'b1;
        dec_ctrl.imm    = imm_b;
        dec_ctrl.branch = 1'b1;
      end
      OPC_LOAD: begin
        illegal          = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        rs1_used         = 1'b1;
        writes_rd        = 1'b1;
        has_funct3       = 1'b1;
        dec_ctrl.imm     = imm_i;
        dec_ctrl.alu_src = 1'b1;
        dec_ctrl.mem_rd  = 1'b1;
        dec_ctrl.wb_sel  = WB_MEM;
      end
      OPC_STORE: begin
        illegal          = (funct3 > 3'b010);
        rs1_used         = 1'b1;
        rs2_used         = 1'b1;
        has_funct3       = 1'b1;
        dec_ctrl.imm     = imm_s;
        dec_ctrl.alu_src = 1'b1;
        dec_ctrl.mem_wr  = 1'b1;
      end
      OPC_OPIMM: begin
        rs1_used         = 1'b1;
        writes_rd        = 1'b1;
        has_funct3       = 1'b1;
        dec_ctrl.imm     = imm_i;
        dec_ctrl.alu_src = 1'b1;
        // Shifts carry funct7 in the immediate; only SRAI may set bit 30
        if (funct3 == 3'b001) begin
          illegal         = (funct7 != 7'b0000000);
          dec_ctrl.alu_op = {funct7[5], funct3};
        end else if (funct3 == 3'b101) begin
          illegal         = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
          dec_ctrl.alu_op = {funct7[5], funct3};
        end else begin
          dec_ctrl.alu_op = {1'b0, funct3};
        end
      end
      OPC_OP: begin
        rs1_used        = 1'b1;
        rs2_used        = 1'b1;
        writes_rd       = 1'b1;
        has_funct3      = 1'b1;
        dec_ctrl.alu_op = {funct7[5], funct3};
        // Only SUB and SRA use the alternate funct7; M-extension is not supported
        illegal = !((funct7 == 7'b0000000) ||
                    ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OPC_FENCE, OPC_SYSTEM: begin
        // Executed as a NOP: no controls asserted
      end
      default: begin
        illegal = 1'b1;
      end
    endcase

    if (i_if_inst == 32'h0000_0000) begin
      // Flushed IF/ID slot: a pure bubble, not an illegal instruction
      dec_ctrl = '0;
      rs1_used = 1'b0;
      rs2_used = 1'b0;
    end else if (illegal) begin
      dec_ctrl         = '0;
      dec_ctrl.pc      = i_if_pc;
      dec_ctrl.illegal = 1'b1;
      rs1_used         = 1'b0;
      rs2_used         = 1'b0;
    end else begin
      // Unused register fields are zeroed so forwarding never matches on them;
      // this also forces rs1 = x0 for LUI so the ALU computes 0 + imm
      dec_ctrl.pc     = i_if_pc;
      dec_ctrl.rs1    = rs1_used ? rs1_f : 5'd0;
      dec_ctrl.rs2    = rs2_used ? rs2_f : 5'd0;
      dec_ctrl.rd     = writes_rd ? rd_f : 5'd0;
      dec_ctrl.funct3 = has_funct3 ? funct3 : 3'b000;
      dec_ctrl.reg_we = writes_rd && (rd_f != 5'd0);
    end
  end

  // Register-file read ports: x0 reads zero, same-cycle WB write is bypassed
  assign rs1_rdata = (dec_ctrl.rs1 == 5'd0) ? '0 :
                     (i_wb_we && (i_wb_rd == dec_ctrl.rs1)) ? i_wb_data : rf_q[dec_ctrl.rs1];
  assign rs2_rdata = (dec_ctrl.rs2 == 5'd0) ? '0 :
                     (i_wb_we && (i_wb_rd == dec_ctrl.rs2)) ? i_wb_data : rf_q[dec_ctrl.rs2];

  // A load in EX whose rd feeds a source actually read here must stall one cycle
  assign o_load_use_stall = i_ex_mem_rd && (i_ex_rd != 5'd0) &&
                            ((rs1_used && (i_ex_rd == rs1_f)) ||
                             (rs2_used && (i_ex_rd == rs2_f)));

  assign idex_d = {dec_ctrl, rs1_rdata, rs2_rdata};

  // Register file storage: cleared on reset, x0 is never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) begin
        rf_q[i] <= '0;
      end
    end else if (i_wb_we && (i_wb_rd != 5'd0)) begin
      rf_q[i_wb_rd] <= i_wb_data;
    end
  end

  // ID/EX register: flush, then load-use stall, insert a bubble; enable captures
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q <= '0;
    end else if (i_flush) begin
      idex_q <= '0;
    end else if (o_load_use_stall) begin
      idex_q <= '0;
    end else if (clk_en_id_reg) begin
      idex_q <= idex_d;
    end
  end

  assign o_id_pc       = idex_q.ctrl.pc;
  assign o_id_rs1_data = idex_q.rs1_data;
  assign o_id_rs2_data = idex_q.rs2_data;
  assign o_id_imm      = idex_q.ctrl.imm;
  assign o_id_rs1      = idex_q.ctrl.rs1;
  assign o_id_rs2      = idex_q.ctrl.rs2;
  assign o_id_rd       = idex_q.ctrl.rd;
  assign o_id_funct3   = idex_q.ctrl.funct3;
  assign o_id_alu_op   = idex_q.ctrl.alu_op;
  assign o_id_alu_src  = idex_q.ctrl.alu_src;
  assign o_id_pc_src   = idex_q.ctrl.pc_src;
  assign o_id_mem_rd   = idex_q.ctrl.mem_rd;
  assign o_id_mem_wr   = idex_q.ctrl.mem_wr;
  assign o_id_reg_we   = idex_q.ctrl.reg_we;
  assign o_id_wb_sel   = idex_q.ctrl.wb_sel;
  assign o_id_branch   = idex_q.ctrl.branch;
  assign o_id_jump     = idex_q.ctrl.jump;
  assign o_id_illegal  = idex_q.ctrl.illegal;

endmodule

// File: tb/tb_instruction_decode.sv
// tb_instruction_decode: directed stimulus for the RV32I ID stage. Each step
// pushes its expected ID/EX contents onto a scoreboard queue; after the clock
// edge the entry is popped and compared with the registered outputs.
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_en_id_reg;
  logic        i_flush;
  logic [31:0] i_if_inst;
  logic [31:0] i_if_pc;
  logic        i_wb_we;
  logic [4:0]  i_wb_rd;
  logic [31:0] i_wb_data;
  logic        i_ex_mem_rd;
  logic [4:0]  i_ex_rd;
  logic        o_load_use_stall;
  logic [31:0] o_id_pc, o_id_rs1_data, o_id_rs2_data, o_id_imm;
  logic [4:0]  o_id_rs1, o_id_rs2, o_id_rd;
  logic [2:0]  o_id_funct3;
  logic [3:0]  o_id_alu_op;
  logic        o_id_alu_src, o_id_pc_src, o_id_mem_rd, o_id_mem_wr, o_id_reg_we;
  logic [1:0]  o_id_wb_sel;
  logic        o_id_branch, o_id_jump, o_id_illegal;

  always #5 clk = ~clk;

  instruction_decode dut (
    .clk(clk), .rst_n(rst_n), .clk_en_id_reg(clk_en_id_reg), .i_flush(i_flush),
    .i_if_inst(i_if_inst), .i_if_pc(i_if_pc),
    .i_wb_we(i_wb_we), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
    .i_ex_mem_rd(i_ex_mem_rd), .i_ex_rd(i_ex_rd),
    .o_load_use_stall(o_load_use_stall), .o_id_pc(o_id_pc),
    .o_id_rs1_data(o_id_rs1_data), .o_id_rs2_data(o_id_rs2_data), .o_id_imm(o_id_imm),
    .o_id_rs1(o_id_rs1), .o_id_rs2(o_id_rs2), .o_id_rd(o_id_rd),
    .o_id_funct3(o_id_funct3), .o_id_alu_op(o_id_alu_op), .o_id_alu_src(o_id_alu_src),
    .o_id_pc_src(o_id_pc_src), .o_id_mem_rd(o_id_mem_rd), .o_id_mem_wr(o_id_mem_wr),
    .o_id_reg_we(o_id_reg_we), .o_id_wb_sel(o_id_wb_sel), .o_id_branch(o_id_branch),
    .o_id_jump(o_id_jump), .o_id_illegal(o_id_illegal)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [3:0]  aluop;
    logic        alusrc;
    logic        pcsrc;
    logic        memrd;
    logic        memwr;
    logic        regwe;
    logic [1:0]  wbsel;
    logic        br;
    logic        jmp;
    logic        ill;
  } idex_t;

  idex_t exp_q[$];
  string tag_q[$];
  idex_t e;
  int    errors = 0;
  int    checks = 0;

  function automatic idex_t observed();
    idex_t o;
    o.pc = o_id_pc;       o.rs1d = o_id_rs1_data; o.rs2d = o_id_rs2_data;
    o.imm = o_id_imm;     o.rs1 = o_id_rs1;       o.rs2 = o_id_rs2;
    o.rd = o_id_rd;       o.f3 = o_id_funct3;     o.aluop = o_id_alu_op;
    o.alusrc = o_id_alu_src; o.pcsrc = o_id_pc_src; o.memrd = o_id_mem_rd;
    o.memwr = o_id_mem_wr;   o.regwe = o_id_reg_we; o.wbsel = o_id_wb_sel;
    o.br = o_id_branch;   o.jmp = o_id_jump;      o.ill = o_id_illegal;
    return o;
  endfunction

  task automatic chk_bus(input string tag, input idex_t got, input idex_t exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input idex_t exp);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  // One clock: after the edge, pop the oldest expectation and compare
  task automatic tick();
    idex_t x;
    string t;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      t = tag_q.pop_front();
      chk_bus(t, observed(), x);
      $display("step %-14s pc=%h inst=%h", t, o_id_pc, i_if_inst);
    end
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc);
    i_if_inst = inst;
    i_if_pc   = pc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; clk_en_id_reg = 1'b1; i_flush = 1'b0;
    i_if_inst = 32'h0; i_if_pc = 32'h0;
    i_wb_we = 1'b0; i_wb_rd = 5'd0; i_wb_data = 32'h0;
    i_ex_mem_rd = 1'b0; i_ex_rd = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_bus("reset_idex", observed(), '0);
    chk1("reset_stall", {31'd0, o_load_use_stall}, 32'd0);
    rst_n = 1'b1;

    // WB x5 while a bubble sits in IF/ID
    i_wb_we = 1'b1; i_wb_rd = 5'd5; i_wb_data = 32'hDEAD_BEEF;
    drive(32'h0000_0000, 32'h0000_000C);
    e = '0; push("bubble_inst0", e); tick();

    // ADD x6,x5,x0
    i_wb_we = 1'b0;
    drive(32'h0002_8333, 32'h10);
    e = '0; e.pc = 32'h10; e.rs1d = 32'hDEAD_BEEF; e.rs1 = 5; e.rd = 6; e.regwe = 1;
    push("add_x6_x5", e); tick();

    // Same-cycle WB x7=0x1234 with ADDI x8,x7,-1 (bypass)
    i_wb_we = 1'b1; i_wb_rd = 5'd7; i_wb_data = 32'h0000_1234;
    drive(32'hFFF3_8413, 32'h14);
    e = '0; e.pc = 32'h14; e.rs1d = 32'h1234; e.imm = 32'hFFFF_FFFF; e.rs1 = 7; e.rd = 8;
    e.alusrc = 1; e.regwe = 1;
    push("addi_bypass", e); tick();

    // WB x0=0xFFFF alongside a read of x0 (ADDI x9,x0,0)
    i_wb_we = 1'b1; i_wb_rd = 5'd0; i_wb_data = 32'h0000_FFFF;
    drive(32'h0000_0493, 32'h18);
    e = '0; e.pc = 32'h18; e.rd = 9; e.alusrc = 1; e.regwe = 1;
    push("x0_bypass", e); tick();

    // x0 must still read zero the cycle after
    i_wb_we = 1'b0;
    drive(32'h0000_0493, 32'h1C);
    e.pc = 32'h1C;
    push("x0_stored", e); tick();

    // ADDI x0,x1,1 -> no register write
    drive(32'h0010_8013, 32'h20);
    e = '0; e.pc = 32'h20; e.rs1 = 1; e.imm = 32'h1; e.alusrc = 1;
    push("addi_rd_x0", e); tick();

    // ADD x10,x7,x5 -> both ports read stored values
    drive(32'h0053_8533, 32'h24);
    e = '0; e.pc = 32'h24; e.rs1d = 32'h1234; e.rs2d = 32'hDEAD_BEEF; e.rs1 = 7; e.rs2 = 5;
    e.rd = 10; e.regwe = 1;
    push("add_x10", e); tick();

    // SUB x11,x5,x7 -> alu_op 1000
    drive(32'h4072_85B3, 32'h28);
    e = '0; e.pc = 32'h28; e.rs1d = 32'hDEAD_BEEF; e.rs2d = 32'h1234; e.rs1 = 5; e.rs2 = 7;
    e.rd = 11; e.aluop = 4'b1000; e.regwe = 1;
    push("sub_x11", e); tick();

    // Load-use: LW x3 in EX, ADD x4,x3,x1 in ID
    i_ex_mem_rd = 1'b1; i_ex_rd = 5'd3;
    drive(32'h0011_8233, 32'h2C);
    #1;
    chk1("loaduse_stall", {31'd0, o_load_use_stall}, 32'd1);
    e = '0; push("loaduse_bubble", e); tick();

    i_ex_mem_rd = 1'b0;
    #1;
    chk1("loaduse_release", {31'd0, o_load_use_stall}, 32'd0);
    e = '0; e.pc = 32'h2C; e.rs1 = 3; e.rs2 = 1; e.rd = 4; e.regwe = 1;
    push("loaduse_issue", e); tick();

    // LUI x12 does not read rs1: no stall even if EX rd matches inst[19:15]
    i_ex_mem_rd = 1'b1; i_ex_rd = 5'd8;
    drive(32'h1234_5637, 32'h30);
    #1;
    chk1("lui_no_stall", {31'd0, o_load_use_stall}, 32'd0);
    e = '0; e.pc = 32'h30; e.imm = 32'h1234_5000; e.rd = 12; e.alusrc = 1; e.regwe = 1;
    push("lui_x12", e); tick();
    i_ex_mem_rd = 1'b0; i_ex_rd = 5'd0;

    // BEQ x1,x2,-8 at 0x100: flushed first, then issued
    i_flush = 1'b1;
    drive(32'hFE20_8CE3, 32'h100);
    e = '0; push("beq_flushed", e); tick();
    i_flush = 1'b0;
    e = '0; e.pc = 32'h100; e.imm = 32'hFFFF_FFF8; e.rs1 = 1; e.rs2 = 2; e.br = 1;
    push("beq_issue", e); tick();

    // Enable low: ID/EX holds the BEQ
    clk_en_id_reg = 1'b0;
    drive(32'h0002_8333, 32'h104);
    push("hold", e); tick();
    clk_en_id_reg = 1'b1;

    // Flush and stall together -> bubble
    i_flush = 1'b1; i_ex_mem_rd = 1'b1; i_ex_rd = 5'd3;
    drive(32'h0011_8233, 32'h108);
    #1;
    chk1("flush_stall_flag", {31'd0, o_load_use_stall}, 32'd1);
    e = '0; push("flush_and_stall", e); tick();
    i_flush = 1'b0; i_ex_mem_rd = 1'b0; i_ex_rd = 5'd0;

    // JAL x1,+16
    drive(32'h0100_00EF, 32'h40);
    e = '0; e.pc = 32'h40; e.imm = 32'h10; e.rd = 1; e.alusrc = 1; e.pcsrc = 1; e.regwe = 1;
    e.wbsel = 2'b10; e.jmp = 1;
    push("jal", e); tick();

    // SW x5,4(x2)
    drive(32'h0051_2223, 32'h44);
    e = '0; e.pc = 32'h44; e.rs2d = 32'hDEAD_BEEF; e.imm = 32'h4; e.rs1 = 2; e.rs2 = 5;
    e.f3 = 3'b010; e.alusrc = 1; e.memwr = 1;
    push("sw", e); tick();

    // LW x3,-4(x7)
    drive(32'hFFC3_A183, 32'h48);
    e = '0; e.pc = 32'h48; e.rs1d = 32'h1234; e.imm = 32'hFFFF_FFFC; e.rs1 = 7; e.rd = 3;
    e.f3 = 3'b010; e.alusrc = 1; e.memrd = 1; e.regwe = 1; e.wbsel = 2'b01;
    push("lw", e); tick();

    // SRAI x13,x5,4 -> alu_op 1101
    drive(32'h4042_D693, 32'h4C);
    e = '0; e.pc = 32'h4C; e.rs1d = 32'hDEAD_BEEF; e.imm = 32'h404; e.rs1 = 5; e.rd = 13;
    e.f3 = 3'b101; e.aluop = 4'b1101; e.alusrc = 1; e.regwe = 1;
    push("srai", e); tick();

    // Opcode 1111111 and MUL are illegal
    drive(32'h0000_057F, 32'h200);
    e = '0; e.pc = 32'h200; e.ill = 1;
    push("illegal_opc", e); tick();
    drive(32'h0200_80B3, 32'h204);
    e = '0; e.pc = 32'h204; e.ill = 1;
    push("illegal_mul", e); tick();

    // ECALL decodes as NOP
    drive(32'h0000_0073, 32'h208);
    e = '0; e.pc = 32'h208;
    push("ecall_nop", e); tick();

    // Capture ADD x10 again, then assert reset between edges
    drive(32'h0053_8533, 32'h50);
    e = '0; e.pc = 32'h50; e.rs1d = 32'h1234; e.rs2d = 32'hDEAD_BEEF; e.rs1 = 7; e.rs2 = 5;
    e.rd = 10; e.regwe = 1;
    push("pre_reset", e); tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_bus("async_reset", observed(), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Register file was cleared: x5 now reads zero
    drive(32'h0002_8333, 32'h60);
    e = '0; e.pc = 32'h60; e.rs1 = 5; e.rd = 6; e.regwe = 1;
    push("rf_cleared", e); tick();

    chk1("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
